vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Free-running VGA raster timing generator for the tt_um_top VGA path (ui_in[7]=1).
//  Produces hsync/vsync, the active-video flag and the current pixel coordinates.
//  The downstream pixel/colour stage uses these to drive uo_out.
//  Default timing is 640x480@60 (800x525 total) from a 25.175 MHz pixel clock.
// PARAMETERS
//  CNT_W     10   width of the hpos/vpos counters; must hold H_TOTAL-1 and V_TOTAL-1
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   hsync pulse width, in pixels
//  H_BP      48   horizontal back porch, in pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vsync pulse width, in lines
//  V_BP      33   vertical back porch, in lines
//  SYNC_POL  0    active level of hsync/vsync (0 = active-low, as in VGA 640x480)
// PORTS
//  clk          in   1      pixel clock; all state changes on its rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  ena          in   1      count enable; when low, all state holds
//  hpos         out  CNT_W  current column, 0..H_TOTAL-1 (registered)
//  vpos         out  CNT_W  current line, 0..V_TOTAL-1 (registered)
//  hsync        out  1      horizontal sync at level SYNC_POL while active (registered)
//  vsync        out  1      vertical sync at level SYNC_POL while active (registered)
//  display_on   out  1      1 when (hpos,vpos) is in the visible area (registered)
//  line_start   out  1      1 when hpos==0 (decoded from registered hpos)
//  frame_start  out  1      1 when hpos==0 && vpos==0 (decoded from registered counters)
// BEHAVIOUR
//  - Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and
//    V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - Reset (rst_n=0, takes effect immediately, no clock needed): hpos=0, vpos=0,
//    display_on=1, hsync=vsync=~SYNC_POL, line_start=1, frame_start=1.
//  - All registered outputs are updated in the same edge, so every output always
//    describes the position currently shown on (hpos,vpos). There is no skew between
//    sync and coordinates; the total latency from counter to output is 0 cycles.
//  - On each rising clk edge with ena=1:
//      hpos = (hpos==H_TOTAL-1) ? 0 : hpos+1
//      vpos advances only when hpos wraps: (vpos==V_TOTAL-1) ? 0 : vpos+1
//  - Decode, applied to the post-update position:
//      hsync active  iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC  (656..751)
//      vsync active  iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC  (490..491)
//      display_on    iff hpos < H_ACTIVE && vpos < V_ACTIVE
//  - ena=0: counters and registered outputs freeze; line_start/frame_start follow
//    the frozen counters. Deasserting and reasserting ena resumes with no skipped
//    or repeated positions.
//  - Wrap-around: at (H_TOTAL-1, V_TOTAL-1) the next edge goes to (0,0), and
//    frame_start is high for exactly that one cycle. One frame is
//    H_TOTAL*V_TOTAL = 420000 enabled cycles.
//  - Reset mid-frame: the async clear overrides everything. Counting restarts at
//    (0,0) on the first enabled edge after rst_n rises.
//  - Counters never leave their legal range; unreachable counter values are not
//    decoded specially.
// TESTING
//  1. Assert rst_n=0 mid-frame without clocking -> hpos=vpos=0, display_on=1,
//     hsync=vsync=1, frame_start=1.
//  2. Apply 656 enabled clocks from reset -> hsync=0 at hpos=656 and display_on=0
//     from hpos=640; hsync returns to 1 at hpos=752.
//  3. Apply 800 enabled clocks -> hpos=0, vpos=1, line_start=1, frame_start=0.
//  4. Apply 800*490 clocks -> vsync=0 on lines 490 and 491 only; vsync=1 at
//     vpos=492,0.
//  5. Apply 420000 clocks -> back at (0,0) with frame_start=1 for one cycle;
//     display_on was high for exactly 307200 cycles.
//  6. Drive ena=0 for 37 cycles at hpos=100 -> all outputs are unchanged. After
//     ena=1, the next edge gives hpos=101. Also run a small-parameter instance
//     (4/1/2/1 x 3/1/1/1) for an exhaustive wrap check.

Source files
------------

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator: pixel/line counters with sync, blanking
// and line/frame markers, all aligned to the position currently on (hpos, vpos).
module vga_sync_gen #(
  parameter int   CNT_W    = 32'd10,
  parameter int   H_ACTIVE = 32'd640,
  parameter int   H_FP     = 32'd16,
  parameter int   H_SYNC   = 32'd96,
  parameter int   H_BP     = 32'd48,
  parameter int   V_ACTIVE = 32'd480,
  parameter int   V_FP     = 32'd10,
  parameter int   V_SYNC   = 32'd2,
  parameter int   V_BP     = 32'd33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 32'd1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 32'd1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hpos_q, hpos_d;
  logic [CNT_W-1:0] vpos_q, vpos_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             disp_q, disp_d;

  // Next position plus decode of that next position, so outputs stay aligned to counters
  always_comb begin
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    disp_d  = disp_q;
    if (ena) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        if (vpos_q == V_LAST) begin
          vpos_d = '0;
        end else begin
          vpos_d = vpos_q + ONE;
        end
      end else begin
        hpos_d = hpos_q + ONE;
        vpos_d = vpos_q;
      end
      hsync_d = ((hpos_d >= HS_START) && (hpos_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d = ((vpos_d >= VS_START) && (vpos_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      disp_d  = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    end else begin
      hpos_d  = hpos_q;
      vpos_d  = vpos_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      disp_d  = disp_q;
    end
  end

  // Counter and decoded-output registers; reset parks the raster at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      disp_q  <= 1'b1;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = disp_q;
  assign line_start  = (hpos_q == '0);
  assign frame_start = (hpos_q == '0) && (vpos_q == '0);

endmodule
